// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset address and bubble instruction.
// Included by if_stage; IF_MISALIGN_TRAP_EN changes how if_stage handles misaligned redirects.
package if_stage_pkg;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_DROP  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [31:0] IF_RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] IF_NOP_INSN   = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, branch redirect and stale-data drop.
// Define IF_MISALIGN_TRAP_EN to trap misaligned branch targets (HALT); otherwise they are aligned.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = IF_RESET_ADDR,
    parameter logic [31:0] NOP_INSN   = IF_NOP_INSN
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        id_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        id_valid,
    output logic        fetch_misaligned
);

    logic [1:0]  r_state, w_state_next;
    logic [31:0] r_fetch_pc, w_fetch_pc_next;
    logic [31:0] r_redirect, w_redirect_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_instr, w_instr_next;
    logic        r_id_valid, w_id_valid_next;
    logic        r_misaligned, w_misaligned_next;
    logic        w_req;
    logic        w_accept;
    logic        w_pending;
    logic        w_bad_target;
    logic [31:0] w_target;

    assign w_target = word_align(branch_target);
`ifdef IF_MISALIGN_TRAP_EN
    assign w_bad_target = (branch_target[1:0] != 2'b00);
`else
    assign w_bad_target = 1'b0;
`endif

    always_comb begin
        case (r_state)
            ST_FETCH: w_req = !r_id_valid || !id_stall;
            ST_DROP:  w_req = 1'b1;
            default:  w_req = 1'b0;
        endcase
        // No request while reset is held, so a late ack to an abandoned fetch is ignored.
        if (rst) w_req = 1'b0;
    end

    assign w_accept  = w_req && imem_ack;
    assign w_pending = w_req && !imem_ack;

    always_comb begin
        w_state_next      = r_state;
        w_fetch_pc_next   = r_fetch_pc;
        w_redirect_next   = r_redirect;
        w_pc_next         = r_pc;
        w_instr_next      = r_instr;
        w_id_valid_next   = r_id_valid;
        w_misaligned_next = r_misaligned;

        case (r_state)
            ST_FETCH: begin
                if (branch_taken) begin
                    w_id_valid_next = 1'b0;
                    w_instr_next    = NOP_INSN;
                    if (w_bad_target) begin
                        w_misaligned_next = 1'b1;
                        w_state_next      = ST_HALT;
                    end else if (w_pending) begin
                        // Address must stay stable until the in-flight word returns.
                        w_redirect_next = w_target;
                        w_state_next    = ST_DROP;
                    end else begin
                        w_fetch_pc_next = w_target;
                    end
                end else if (w_accept) begin
                    w_pc_next       = r_fetch_pc;
                    w_instr_next    = imem_data;
                    w_id_valid_next = 1'b1;
                    w_fetch_pc_next = r_fetch_pc + 32'd4;
                end else if (!id_stall) begin
                    w_id_valid_next = 1'b0;
                    w_instr_next    = NOP_INSN;
                end
            end
            ST_DROP: begin
                if (branch_taken && w_bad_target) begin
                    w_misaligned_next = 1'b1;
                    w_state_next      = ST_HALT;
                end else begin
                    if (branch_taken) w_redirect_next = w_target;
                    if (imem_ack) begin
                        w_fetch_pc_next = branch_taken ? w_target : r_redirect;
                        w_state_next    = ST_FETCH;
                    end
                end
            end
            default: begin
                if (branch_taken && !w_bad_target) begin
                    w_misaligned_next = 1'b0;
                    w_fetch_pc_next   = w_target;
                    w_state_next      = ST_FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_fetch_pc   <= RESET_ADDR;
            r_redirect   <= RESET_ADDR;
            r_pc         <= RESET_ADDR;
            r_instr      <= NOP_INSN;
            r_id_valid   <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_fetch_pc   <= w_fetch_pc_next;
            r_redirect   <= w_redirect_next;
            r_pc         <= w_pc_next;
            r_instr      <= w_instr_next;
            r_id_valid   <= w_id_valid_next;
            r_misaligned <= w_misaligned_next;
        end
    end

    assign imem_req         = w_req;
    assign imem_addr        = r_fetch_pc;
    assign pc               = r_pc;
    assign instruction      = r_instr;
    assign id_valid         = r_id_valid;
    assign fetch_misaligned = r_misaligned;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; memory words are addr ^ 32'hA5A5_0000.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        id_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        id_valid;
    logic        fetch_misaligned;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_stage dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_data        (imem_data),
        .id_stall         (id_stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .pc               (pc),
        .instruction      (instruction),
        .id_valid         (id_valid),
        .fetch_misaligned (fetch_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Advance one rising edge, then settle past it before driving/sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_data = 32'h0; id_stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        tick(); tick();
        tests++; if (imem_req !== 1'b0) begin fails++;
            $display("FAIL rst_req: got %b exp 0", imem_req); end
        tests++; if (pc !== 32'h0) begin fails++;
            $display("FAIL rst_pc: got %h exp 00000000", pc); end
        tests++; if (instruction !== NOP) begin fails++;
            $display("FAIL rst_instr: got %h exp %h", instruction, NOP); end
        tests++; if (id_valid !== 1'b0) begin fails++;
            $display("FAIL rst_valid: got %b exp 0", id_valid); end
        tests++; if (fetch_misaligned !== 1'b0) begin fails++;
            $display("FAIL rst_misaligned: got %b exp 0", fetch_misaligned); end
        rst = 1'b0;
        #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++;
            $display("FAIL first_req: got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; imem_data = mem(32'(4 * i));
            #1;
            tests++; if (imem_addr !== 32'(4 * i) || imem_req !== 1'b1) begin fails++;
                $display("FAIL seq_addr%0d: got req=%b addr=%h exp req=1 addr=%h",
                         i, imem_req, imem_addr, 32'(4 * i)); end
            tick();
            tests++; if (id_valid !== 1'b1 || pc !== 32'(4 * i) || instruction !== mem(32'(4 * i)))
            begin fails++;
                $display("FAIL seq_out%0d: got v=%b pc=%h ins=%h exp v=1 pc=%h ins=%h",
                         i, id_valid, pc, instruction, 32'(4 * i), mem(32'(4 * i))); end
        end
    endtask

    task automatic test_stall();
        id_stall = 1'b1; imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        #1;
        tests++; if (imem_req !== 1'b0) begin fails++;
            $display("FAIL stall_req: got %b exp 0", imem_req); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (pc !== 32'h8 || instruction !== mem(32'h8) || id_valid !== 1'b1 ||
                         imem_req !== 1'b0) begin fails++;
                $display("FAIL stall_hold%0d: got pc=%h ins=%h v=%b req=%b exp pc=8 ins=%h v=1 req=0",
                         i, pc, instruction, id_valid, imem_req, mem(32'h8)); end
        end
        id_stall = 1'b0; imem_data = mem(32'hC);
        #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin fails++;
            $display("FAIL stall_resume: got req=%b addr=%h exp req=1 addr=c", imem_req, imem_addr); end
        tick();
        tests++; if (pc !== 32'hC || instruction !== mem(32'hC)) begin fails++;
            $display("FAIL stall_next: got pc=%h ins=%h exp pc=c ins=%h", pc, instruction, mem(32'hC)); end
        imem_ack = 1'b0;
        tick();
        tests++; if (id_valid !== 1'b0 || instruction !== NOP || pc !== 32'hC ||
                     imem_addr !== 32'h10) begin fails++;
            $display("FAIL bubble: got v=%b ins=%h pc=%h addr=%h exp v=0 ins=%h pc=c addr=10",
                     id_valid, instruction, pc, imem_addr, NOP); end
    endtask

    task automatic test_branch_drop();
        branch_taken = 1'b1; branch_target = 32'h100; imem_ack = 1'b0;
        tick();
        branch_taken = 1'b0;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || id_valid !== 1'b0) begin fails++;
            $display("FAIL drop_enter: got req=%b addr=%h v=%b exp req=1 addr=10 v=0",
                     imem_req, imem_addr, id_valid); end
        tick();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || id_valid !== 1'b0) begin fails++;
            $display("FAIL drop_wait: got req=%b addr=%h v=%b exp req=1 addr=10 v=0",
                     imem_req, imem_addr, id_valid); end
        imem_ack = 1'b1; imem_data = 32'hBAD0_0000;
        tick();
        tests++; if (id_valid !== 1'b0 || instruction !== NOP || imem_addr !== 32'h100) begin fails++;
            $display("FAIL drop_discard: got v=%b ins=%h addr=%h exp v=0 ins=%h addr=100",
                     id_valid, instruction, imem_addr, NOP); end
        imem_data = mem(32'h100);
        tick();
        tests++; if (id_valid !== 1'b1 || pc !== 32'h100 || instruction !== mem(32'h100)) begin
            fails++;
            $display("FAIL drop_target: got v=%b pc=%h ins=%h exp v=1 pc=100 ins=%h",
                     id_valid, pc, instruction, mem(32'h100)); end
    endtask

    task automatic test_branch_ack_same();
        imem_ack = 1'b1; imem_data = 32'hBAD1_0000; branch_taken = 1'b1; branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        tests++; if (id_valid !== 1'b0 || instruction !== NOP || imem_addr !== 32'h200) begin fails++;
            $display("FAIL same_cycle: got v=%b ins=%h addr=%h exp v=0 ins=%h addr=200",
                     id_valid, instruction, imem_addr, NOP); end
        imem_data = mem(32'h200);
        tick();
        tests++; if (id_valid !== 1'b1 || pc !== 32'h200 || instruction !== mem(32'h200)) begin
            fails++;
            $display("FAIL same_next: got v=%b pc=%h ins=%h exp v=1 pc=200 ins=%h",
                     id_valid, pc, instruction, mem(32'h200)); end
    endtask

    task automatic test_wrap();
        imem_ack = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0; imem_data = mem(32'hFFFF_FFFC);
        tests++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++;
            $display("FAIL wrap_addr: got %h exp fffffffc", imem_addr); end
        tick();
        tests++; if (pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin fails++;
            $display("FAIL wrap_next: got pc=%h addr=%h exp pc=fffffffc addr=0", pc, imem_addr); end
        imem_data = mem(32'h0);
        tick();
        tests++; if (pc !== 32'h0 || instruction !== mem(32'h0)) begin fails++;
            $display("FAIL wrap_pc: got pc=%h ins=%h exp pc=0 ins=%h", pc, instruction, mem(32'h0)); end
    endtask

    task automatic test_branch_in_drop();
        imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
        tick();
        branch_target = 32'h400;
        tick();
        branch_taken = 1'b0;
        tests++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin fails++;
            $display("FAIL redrop_hold: got req=%b addr=%h exp req=1 addr=4", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_data = 32'hBAD2_0000;
        tick();
        tests++; if (imem_addr !== 32'h400 || id_valid !== 1'b0) begin fails++;
            $display("FAIL redrop_target: got addr=%h v=%b exp addr=400 v=0", imem_addr, id_valid); end
        imem_data = mem(32'h400);
        tick();
        tests++; if (pc !== 32'h400 || id_valid !== 1'b1) begin fails++;
            $display("FAIL redrop_pc: got pc=%h v=%b exp pc=400 v=1", pc, id_valid); end
    endtask

    task automatic test_misalign();
`ifdef IF_MISALIGN_TRAP_EN
        imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h102;
        tick();
        branch_taken = 1'b0; imem_ack = 1'b1; imem_data = 32'hBAD3_0000;
        #1;
        tests++; if (fetch_misaligned !== 1'b1 || imem_req !== 1'b0 || id_valid !== 1'b0) begin
            fails++;
            $display("FAIL trap_set: got m=%b req=%b v=%b exp m=1 req=0 v=0",
                     fetch_misaligned, imem_req, id_valid); end
        tick();
        tests++; if (fetch_misaligned !== 1'b1 || imem_req !== 1'b0 || id_valid !== 1'b0) begin
            fails++;
            $display("FAIL trap_sticky: got m=%b req=%b v=%b exp m=1 req=0 v=0",
                     fetch_misaligned, imem_req, id_valid); end
        imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        tests++; if (fetch_misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            fails++;
            $display("FAIL trap_clear: got m=%b req=%b addr=%h exp m=0 req=1 addr=200",
                     fetch_misaligned, imem_req, imem_addr); end
        imem_ack = 1'b1; imem_data = mem(32'h200);
        tick();
        tests++; if (pc !== 32'h200 || id_valid !== 1'b1) begin fails++;
            $display("FAIL trap_resume: got pc=%h v=%b exp pc=200 v=1", pc, id_valid); end
`else
        imem_ack = 1'b1; branch_taken = 1'b1; branch_target = 32'h102;
        tick();
        branch_taken = 1'b0;
        tests++; if (imem_addr !== 32'h100 || fetch_misaligned !== 1'b0 || imem_req !== 1'b1) begin
            fails++;
            $display("FAIL align_force: got addr=%h m=%b req=%b exp addr=100 m=0 req=1",
                     imem_addr, fetch_misaligned, imem_req); end
        imem_data = mem(32'h100);
        tick();
        tests++; if (pc !== 32'h100 || id_valid !== 1'b1 || fetch_misaligned !== 1'b0) begin
            fails++;
            $display("FAIL align_pc: got pc=%h v=%b m=%b exp pc=100 v=1 m=0",
                     pc, id_valid, fetch_misaligned); end
`endif
    endtask

    task automatic test_reset_mid();
        imem_ack = 1'b0; branch_taken = 1'b0; id_stall = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        tests++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || pc !== 32'h0 ||
                     instruction !== NOP) begin fails++;
            $display("FAIL midrst_clear: got req=%b v=%b pc=%h ins=%h exp req=0 v=0 pc=0 ins=%h",
                     imem_req, id_valid, pc, instruction, NOP); end
        imem_ack = 1'b1; imem_data = 32'hBAD4_0000;
        tick();
        tests++; if (id_valid !== 1'b0 || instruction !== NOP) begin fails++;
            $display("FAIL midrst_ack: got v=%b ins=%h exp v=0 ins=%h", id_valid, instruction, NOP); end
        imem_ack = 1'b0; rst = 1'b0;
        #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++;
            $display("FAIL midrst_restart: got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_drop();
        test_branch_ack_same();
        test_wrap();
        test_branch_in_drop();
        test_misalign();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
